sim_result_checker: RTL and testbench
=====================================

SIM_RESULT_CHECKER -- requirements
Module: sim_result_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of the observed result bus.
REQ-002 SHALL have parameter DEPTH, default 16, number of expected-value table entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 1000, maximum RUN cycles before timeout (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port exp_we  input  1  expected-table write enable.
REQ-007 SHALL have port exp_addr  input  $clog2(DEPTH)  expected-table write address.
REQ-008 SHALL have port exp_data  input  WIDTH  expected-table write data.
REQ-009 SHALL have port exp_count  input  $clog2(DEPTH)+1  number of entries to check, sampled on start.
REQ-010 SHALL have port start  input  1  begin a checking run.
REQ-011 SHALL have port result  input  WIDTH  processor result under observation.
REQ-012 SHALL have port result_valid  input  1  result is a new retired value this cycle.
REQ-013 SHALL have outputs busy, done, pass, fail, timed_out  output  1 each  status flags.
REQ-014 SHALL have output err_index  output  $clog2(DEPTH)  table index of first mismatch.
REQ-015 SHALL have output err_got  output  WIDTH  result value at first mismatch.
REQ-016 SHALL have output cycle_count  output  32  RUN cycles elapsed.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, PASS, FAIL, TIMEOUT; all outputs registered.
REQ-018 SHALL write exp_data to table[exp_addr] on exp_we only in IDLE, PASS, FAIL, TIMEOUT; exp_we in RUN ignored.
REQ-019 SHALL, on start outside RUN with exp_count in 1..DEPTH, latch exp_count, clear idx, cycle_count, err_index, err_got, go to RUN next cycle.
REQ-020 SHALL, on start with exp_count==0, go directly to PASS next cycle with cycle_count=0.
REQ-021 SHALL clamp exp_count > DEPTH to DEPTH.
REQ-022 SHALL ignore start while in RUN.
REQ-023 SHALL in RUN increment cycle_count by 1 every cycle, wrapping at 2^32.
REQ-024 SHALL in RUN, when result_valid=1, compare result against table[idx] (full WIDTH, exact equality).
REQ-025 SHALL on match increment idx; if idx was latched_count-1, go to PASS next cycle.
REQ-026 SHALL on mismatch capture err_index=idx, err_got=result, go to FAIL next cycle.
REQ-027 SHALL go to TIMEOUT when cycle_count reaches TIMEOUT-1 and no PASS/FAIL transition occurs that cycle.
REQ-028 SHALL give a result_valid comparison priority over timeout in the same cycle.
REQ-029 SHALL freeze cycle_count, idx, err_* in PASS, FAIL, TIMEOUT until next start or reset.
REQ-030 SHALL drive busy=1 only in RUN; done=1 in PASS, FAIL, TIMEOUT; pass/fail/timed_out one-hot with matching state.
REQ-031 SHALL leave the expected table contents unchanged by reset and by start.

Reset
REQ-032 SHALL, when reset=0 at a rising edge, enter IDLE and clear busy, done, pass, fail, timed_out, err_index, err_got, cycle_count to 0, regardless of current state.
REQ-033 SHALL treat reset asserted mid-RUN as an abort: no PASS/FAIL/TIMEOUT flag set that cycle.

Verification
REQ-034 SHALL verify: load table 0..3 = 0x5,0xA,0xF,0x14, exp_count=4, start, feed those four values on valid -> pass=1, done=1, cycle_count frozen, fail=0.
REQ-035 SHALL verify: same table, feed 0x5, 0xB -> fail=1, err_index=1, err_got=0x0000000B, next cycles unchanged.
REQ-036 SHALL verify: TIMEOUT=8, exp_count=2, result_valid held 0 -> timed_out=1 after 8 RUN cycles, cycle_count=7.
REQ-037 SHALL verify: last matching result_valid on the cycle cycle_count=TIMEOUT-1 -> pass=1, timed_out=0.
REQ-038 SHALL verify: reset=0 mid-RUN -> IDLE, all flags 0; restart with start re-runs using retained table and passes.
REQ-039 SHALL verify: start with exp_count=0 -> pass=1 next cycle; exp_we during RUN does not alter table (later read-back via matching run).

Source files
------------

// File: rtl/sim_result_checker.sv
// Compares a stream of retired results against a preloaded expected-value table
// and reports pass / first-mismatch / timeout with registered status flags.
module sim_result_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_addr,
  input  logic [WIDTH-1:0]         exp_data,
  input  logic [$clog2(DEPTH):0]   exp_count,
  input  logic                     start,
  input  logic [WIDTH-1:0]         result,
  input  logic                     result_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timed_out,
  output logic [$clog2(DEPTH)-1:0] err_index,
  output logic [WIDTH-1:0]         err_got,
  output logic [31:0]              cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT_S} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     idx;
  logic [AW:0]       cnt;
  logic [AW:0]       cnt_clamped;
  logic [AW:0]       last_idx;
  logic              match;
  logic [4:0]        flags_n;

  assign cnt_clamped = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
  assign last_idx    = cnt - 1'b1;
  assign match       = (result == mem[idx]);

  // Table has no reset so its contents survive reset and start.
  always_ff @(posedge clk) begin
    if (exp_we && state != RUN) mem[exp_addr] <= exp_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Result comparison outranks the timeout check in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      RUN: begin
        if (result_valid && !match)                          state_n = FAIL;
        else if (result_valid && ({1'b0, idx} == last_idx))  state_n = PASS;
        else if (cycle_count == TO_LAST)                     state_n = TIMEOUT_S;
      end
      default: begin
        if (start) state_n = (exp_count == '0) ? PASS : RUN;
      end
    endcase
  end

  always_comb begin
    flags_n = '0;
    case (state_n)
      RUN:       flags_n = 5'b10000;
      PASS:      flags_n = 5'b01100;
      FAIL:      flags_n = 5'b01010;
      TIMEOUT_S: flags_n = 5'b01001;
      default:   flags_n = '0;
    endcase
  end

  // cycle_count only advances while staying in RUN, so it freezes at the exit cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {busy, done, pass, fail, timed_out} <= '0;
      err_index   <= '0;
      err_got     <= '0;
      cycle_count <= '0;
      idx         <= '0;
      cnt         <= '0;
    end else begin
      {busy, done, pass, fail, timed_out} <= flags_n;
      if (state != RUN) begin
        if (start) begin
          cnt         <= cnt_clamped;
          idx         <= '0;
          cycle_count <= '0;
          err_index   <= '0;
          err_got     <= '0;
        end
      end else begin
        if (result_valid && match) idx <= idx + 1'b1;
        if (result_valid && !match) begin
          err_index <= idx;
          err_got   <= result;
        end
        if (state_n == RUN) cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sim_result_checker.sv
// Directed bench for sim_result_checker: pass, mismatch, timeout, reset abort,
// empty run, writes ignored during RUN, and exp_count clamping.
module tb_sim_result_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [4:0]  exp_count = '0;
  logic        start = 1'b0;
  logic [31:0] result = '0;
  logic        result_valid = 1'b0;

  logic        busy, done, pass, fail, timed_out;
  logic [3:0]  err_index;
  logic [31:0] err_got, cycle_count;
  logic        b_busy, b_done, b_pass, b_fail, b_timed_out;
  logic [3:0]  b_err_index;
  logic [31:0] b_err_got, b_cycle_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sim_result_checker #(.WIDTH(32), .DEPTH(16), .TIMEOUT(8)) u_dut (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_count(exp_count), .start(start),
    .result(result), .result_valid(result_valid),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timed_out(timed_out),
    .err_index(err_index), .err_got(err_got), .cycle_count(cycle_count)
  );

  sim_result_checker #(.WIDTH(32), .DEPTH(16), .TIMEOUT(64)) u_big (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_count(exp_count), .start(start),
    .result(result), .result_valid(result_valid),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail), .timed_out(b_timed_out),
    .err_index(b_err_index), .err_got(b_err_got), .cycle_count(b_cycle_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [4:0] n);
    exp_count = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] v);
    result = v;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
  endtask

  task automatic load_table();
    for (int i = 0; i < 16; i++) begin
      exp_we = 1'b1;
      exp_addr = 4'(i);
      exp_data = 32'(5 * (i + 1));
      step();
    end
    exp_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, pass, fail, timed_out});
    end
    checks++;
    if ({err_index, err_got, cycle_count} !== '0) begin
      errors++; $display("FAIL reset_regs got idx=%0h got=%0h cyc=%0d exp all 0", err_index, err_got, cycle_count);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_pass();
    run_start(5'd4);
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b10000) begin
      errors++; $display("FAIL pass_run_flags got=%b exp=10000", {busy, done, pass, fail, timed_out});
    end
    feed(32'h5); feed(32'hA); feed(32'hF); feed(32'h14);
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b01100) begin
      errors++; $display("FAIL pass_flags got=%b exp=01100", {busy, done, pass, fail, timed_out});
    end
    checks++;
    if (cycle_count !== 32'd3) begin
      errors++; $display("FAIL pass_cycles got=%0d exp=3", cycle_count);
    end
    step(); step();
    checks++;
    if ({pass, fail, cycle_count} !== {1'b1, 1'b0, 32'd3}) begin
      errors++; $display("FAIL pass_frozen got pass=%b fail=%b cyc=%0d exp 1 0 3", pass, fail, cycle_count);
    end
  endtask

  task automatic test_mismatch();
    run_start(5'd4);
    feed(32'h5); feed(32'hB);
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b01010) begin
      errors++; $display("FAIL mm_flags got=%b exp=01010", {busy, done, pass, fail, timed_out});
    end
    checks++;
    if (err_index !== 4'd1 || err_got !== 32'h0000000B || cycle_count !== 32'd1) begin
      errors++; $display("FAIL mm_capture got idx=%0d got=%h cyc=%0d exp 1 0000000b 1", err_index, err_got, cycle_count);
    end
    feed(32'h77); feed(32'hF); step();
    checks++;
    if ({fail, err_index, err_got, cycle_count} !== {1'b1, 4'd1, 32'h0000000B, 32'd1}) begin
      errors++; $display("FAIL mm_frozen got fail=%b idx=%0d got=%h cyc=%0d", fail, err_index, err_got, cycle_count);
    end
  endtask

  task automatic test_timeout();
    run_start(5'd2);
    for (int i = 0; i < 7; i++) step();
    checks++;
    if ({busy, timed_out, cycle_count} !== {1'b1, 1'b0, 32'd7}) begin
      errors++; $display("FAIL to_before got busy=%b to=%b cyc=%0d exp 1 0 7", busy, timed_out, cycle_count);
    end
    step();
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b01001 || cycle_count !== 32'd7) begin
      errors++; $display("FAIL to_flags got=%b cyc=%0d exp=01001 7", {busy, done, pass, fail, timed_out}, cycle_count);
    end
  endtask

  task automatic test_last_cycle_pass();
    run_start(5'd2);
    for (int i = 0; i < 6; i++) step();
    feed(32'h5);
    checks++;
    if ({busy, cycle_count} !== {1'b1, 32'd7}) begin
      errors++; $display("FAIL edge_pre got busy=%b cyc=%0d exp 1 7", busy, cycle_count);
    end
    feed(32'hA);
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b01100 || cycle_count !== 32'd7) begin
      errors++; $display("FAIL edge_pass got=%b cyc=%0d exp=01100 7", {busy, done, pass, fail, timed_out}, cycle_count);
    end
  endtask

  task automatic test_abort_restart();
    run_start(5'd4);
    feed(32'h5);
    reset = 1'b0;
    result = 32'hA; result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b00000 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL abort got=%b cyc=%0d exp=00000 0", {busy, done, pass, fail, timed_out}, cycle_count);
    end
    reset = 1'b1;
    step();
    run_start(5'd4);
    feed(32'h5); feed(32'hA); feed(32'hF); feed(32'h14);
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b01100) begin
      errors++; $display("FAIL restart_pass got=%b exp=01100", {busy, done, pass, fail, timed_out});
    end
  endtask

  task automatic test_empty_and_we_in_run();
    run_start(5'd0);
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b01100 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL empty got=%b cyc=%0d exp=01100 0", {busy, done, pass, fail, timed_out}, cycle_count);
    end
    run_start(5'd4);
    exp_we = 1'b1; exp_addr = 4'd2; exp_data = 32'hDEAD;
    step();
    exp_we = 1'b0;
    feed(32'h5); feed(32'hA); feed(32'hF); feed(32'h14);
    checks++;
    if ({busy, done, pass, fail, timed_out} !== 5'b01100) begin
      errors++; $display("FAIL we_in_run got=%b exp=01100 err_got=%h", {busy, done, pass, fail, timed_out}, err_got);
    end
  endtask

  task automatic test_clamp();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    run_start(5'd20);
    for (int i = 0; i < 15; i++) feed(32'(5 * (i + 1)));
    checks++;
    if ({b_busy, b_done, b_pass, b_fail, b_timed_out} !== 5'b10000 || b_cycle_count !== 32'd15) begin
      errors++; $display("FAIL clamp_pre got=%b cyc=%0d exp=10000 15", {b_busy, b_done, b_pass, b_fail, b_timed_out}, b_cycle_count);
    end
    feed(32'd80);
    checks++;
    if ({b_busy, b_done, b_pass, b_fail, b_timed_out} !== 5'b01100 || b_cycle_count !== 32'd15) begin
      errors++; $display("FAIL clamp_pass got=%b cyc=%0d exp=01100 15", {b_busy, b_done, b_pass, b_fail, b_timed_out}, b_cycle_count);
    end
  endtask

  initial begin
    test_reset();
    load_table();
    test_pass();
    test_mismatch();
    test_timeout();
    test_last_cycle_pass();
    test_abort_restart();
    test_empty_and_we_in_run();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
